// File: rtl/uart_frame_tx_if.sv
// Handshake bundle between the tick counter and the UART frame transmitter.
interface uart_frame_tx_if #(
    parameter int unsigned FRAME_LEN = 4
);
    logic                     trigger;
    logic [8*FRAME_LEN-1:0]   frame_data;
    logic                     tx;
    logic                     busy;
    logic                     done;
    logic                     overrun;

    modport master (
        output trigger,
        output frame_data,
        input  tx,
        input  busy,
        input  done,
        input  overrun
    );

    modport slave (
        input  trigger,
        input  frame_data,
        output tx,
        output busy,
        output done,
        output overrun
    );
endinterface

// File: rtl/uart_frame_tx.sv
// Multi-byte UART transmitter (8N1, LSB first): a trigger latches a frame, done pulses at its end.
// Optional even parity bit per byte when UART_PARITY_EN is defined.
module uart_frame_tx #(
    parameter int unsigned BAUD_DIV  = 868,
    parameter int unsigned FRAME_LEN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_frame_tx_if.slave  bus
);
    localparam int unsigned DATA_W = 8 * FRAME_LEN;
    localparam int unsigned CNT_W  = $clog2(BAUD_DIV);
    localparam int unsigned BYTE_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state_q, state_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [2:0]          bit_q, bit_n;
    logic [BYTE_W-1:0]   byte_q, byte_n;
    logic [DATA_W-1:0]   sbuf_q, sbuf_n;
    logic                tx_q, tx_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;
    logic                overrun_q, overrun_n;
    logic                bit_end_c;
    logic [7:0]          cur_byte_c;

    assign bit_end_c  = (cnt_q == CNT_W'(BAUD_DIV - 1));
    assign cur_byte_c = sbuf_q[7:0];

    // State and datapath registers; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            sbuf_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            bit_q     <= bit_n;
            byte_q    <= byte_n;
            sbuf_q    <= sbuf_n;
            tx_q      <= tx_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            overrun_q <= overrun_n;
        end
    end

    // Next-state logic; tx_n is the level for the bit that starts at the coming edge.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        bit_n     = bit_q;
        byte_n    = byte_q;
        sbuf_n    = sbuf_q;
        tx_n      = tx_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        overrun_n = 1'b0;

        if (state_q != IDLE) begin
            cnt_n = bit_end_c ? '0 : cnt_q + CNT_W'(1);
            if (bus.trigger) begin
                overrun_n = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (bus.trigger) begin
                    sbuf_n  = bus.frame_data;
                    byte_n  = '0;
                    bit_n   = '0;
                    cnt_n   = '0;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end_c) begin
                    bit_n   = '0;
                    tx_n    = cur_byte_c[0];
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_n    = ^cur_byte_c;
                        state_n = PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_q + 3'd1;
                        tx_n  = cur_byte_c[bit_q + 3'd1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_end_c) begin
                    tx_n    = 1'b1;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end_c) begin
                    if (byte_q == BYTE_W'(FRAME_LEN - 1)) begin
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        // Next byte follows immediately with its start bit.
                        byte_n  = byte_q + BYTE_W'(1);
                        sbuf_n  = sbuf_q >> 8;
                        tx_n    = 1'b0;
                        state_n = START;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx with BAUD_DIV=4; frame setup follows UART_PARITY_EN.
module tb_uart_frame_tx;
    localparam int BD = 4;
`ifdef UART_PARITY_EN
    localparam int FL  = 1;
    localparam int BPB = 11;
    localparam logic PAR = 1'b1;
    localparam logic [7:0] DATA = 8'h01;
`else
    localparam int FL  = 2;
    localparam int BPB = 10;
    localparam logic PAR = 1'b0;
    localparam logic [15:0] DATA = 16'hA55A;
`endif
    localparam int W = 8 * FL;
    localparam int N = BPB * FL * BD;

    typedef struct {
        int   k;
        logic tx;
        logic busy;
        logic done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    logic tx_tr   [0:511];
    logic busy_tr [0:511];
    logic done_tr [0:511];
    logic ovr_tr  [0:511];

    uart_frame_tx_if #(.FRAME_LEN(FL)) bus ();

    uart_frame_tx #(.BAUD_DIV(BD), .FRAME_LEN(FL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int k, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s k=%0d got=%b want=%b", name, k, act, exp);
    endtask

    // Expected line level j cycles after the accepting edge of a frame carrying d.
    function automatic logic exp_tx(input int j, input logic [W-1:0] d);
        int bitn, b, p;
        logic [7:0] byt;
        if (j < 0 || j >= N) return 1'b1;
        bitn = j / BD;
        b    = bitn / BPB;
        p    = bitn % BPB;
        byt  = d[8*b +: 8];
        if (p == 0) return 1'b0;
        if (p <= 8) return byt[p-1];
        if (PAR && p == 9) return ^byt;
        return 1'b1;
    endfunction

    // Pulse trigger, then record outputs after edges E0..E(len-1).
    task automatic run_trace(input int len, input int retrig_k, input int chg_k,
                             input logic [W-1:0] chg_val);
        @(negedge clk);
        bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            tx_tr[k]   = bus.tx;
            busy_tr[k] = bus.busy;
            done_tr[k] = bus.done;
            ovr_tr[k]  = bus.overrun;
            bus.trigger = (k == retrig_k);
            if (k == chg_k) bus.frame_data = chg_val;
        end
        bus.trigger = 1'b0;
    endtask

    task automatic compare_trace(input string name, input int len, input logic [W-1:0] d,
                                 input int off2, input int ovr_k);
        logic et, eb, ed;
        for (int k = 0; k < len; k++) begin
            et = exp_tx(k, d);
            eb = (k < N);
            ed = (k == N);
            if (off2 >= 0) begin
                et = et & exp_tx(k - off2, d);
                eb = eb | (k >= off2 && k < off2 + N);
                ed = ed | (k == off2 + N);
            end
            chk({name, "_tx"},   k, tx_tr[k],   et);
            chk({name, "_busy"}, k, busy_tr[k], eb);
            chk({name, "_done"}, k, done_tr[k], ed);
            chk({name, "_ovr"},  k, ovr_tr[k],  (k == ovr_k));
        end
    endtask

    vec_t vecs[$];

    initial begin
        bus.trigger    = 1'b0;
        bus.frame_data = DATA;

`ifdef UART_PARITY_EN
        vecs = '{
            '{0, 1'b0, 1'b1, 1'b0}, '{4, 1'b1, 1'b1, 1'b0}, '{8, 1'b0, 1'b1, 1'b0},
            '{32, 1'b0, 1'b1, 1'b0}, '{36, 1'b1, 1'b1, 1'b0}, '{40, 1'b1, 1'b1, 1'b0},
            '{43, 1'b1, 1'b1, 1'b0}, '{44, 1'b1, 1'b0, 1'b1}, '{45, 1'b1, 1'b0, 1'b0}
        };
`else
        vecs = '{
            '{0, 1'b0, 1'b1, 1'b0},  '{3, 1'b0, 1'b1, 1'b0},  '{4, 1'b0, 1'b1, 1'b0},
            '{8, 1'b1, 1'b1, 1'b0},  '{12, 1'b0, 1'b1, 1'b0}, '{16, 1'b1, 1'b1, 1'b0},
            '{20, 1'b1, 1'b1, 1'b0}, '{24, 1'b0, 1'b1, 1'b0}, '{28, 1'b1, 1'b1, 1'b0},
            '{32, 1'b0, 1'b1, 1'b0}, '{36, 1'b1, 1'b1, 1'b0}, '{40, 1'b0, 1'b1, 1'b0},
            '{44, 1'b1, 1'b1, 1'b0}, '{48, 1'b0, 1'b1, 1'b0}, '{52, 1'b1, 1'b1, 1'b0},
            '{56, 1'b0, 1'b1, 1'b0}, '{60, 1'b0, 1'b1, 1'b0}, '{64, 1'b1, 1'b1, 1'b0},
            '{68, 1'b0, 1'b1, 1'b0}, '{72, 1'b1, 1'b1, 1'b0}, '{76, 1'b1, 1'b1, 1'b0},
            '{79, 1'b1, 1'b1, 1'b0}, '{80, 1'b1, 1'b0, 1'b1}, '{81, 1'b1, 1'b0, 1'b0}
        };
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", 0, bus.tx, 1'b1);
        chk("rst_busy", 0, bus.busy, 1'b0);
        chk("rst_done", 0, bus.done, 1'b0);
        chk("rst_ovr", 0, bus.overrun, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame: hand table plus full-waveform model
        run_trace(N + 3, -1, -1, '0);
        foreach (vecs[i]) begin
            chk("tbl_tx",   vecs[i].k, tx_tr[vecs[i].k],   vecs[i].tx);
            chk("tbl_busy", vecs[i].k, busy_tr[vecs[i].k], vecs[i].busy);
            chk("tbl_done", vecs[i].k, done_tr[vecs[i].k], vecs[i].done);
        end
        compare_trace("single", N + 3, DATA, -1, -1);
        repeat (3) @(negedge clk);

        // Trigger sampled at E10 while busy
        run_trace(N + 3, 9, -1, '0);
        compare_trace("overrun", N + 3, DATA, -1, 10);
        repeat (3) @(negedge clk);

        // Payload changed right after latching
        run_trace(N + 3, -1, 0, '0);
        compare_trace("latch", N + 3, DATA, -1, -1);
        bus.frame_data = DATA;
        repeat (3) @(negedge clk);

        // Trigger sampled at E(N+1), the cycle after done
        run_trace(2 * N + 4, N, -1, '0);
        compare_trace("b2b", 2 * N + 4, DATA, N + 1, -1);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-frame
        @(negedge clk);
        bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        repeat (29) @(negedge clk);
        chk("pre_rst_busy", 29, bus.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_tx", 30, bus.tx, 1'b1);
        chk("async_busy", 30, bus.busy, 1'b0);
        chk("async_done", 30, bus.done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_done", 31 + i, bus.done, 1'b0);
            chk("rst_hold_tx", 31 + i, bus.tx, 1'b1);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle_tx", 0, bus.tx, 1'b1);
        chk("post_rst_idle_done", 0, bus.done, 1'b0);
        run_trace(N + 3, -1, -1, '0);
        compare_trace("after_rst", N + 3, DATA, -1, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
